// File: rtl/bus_seq_pkg.sv
// Shared definitions for the 68000 bus sequencer: FSM encoding, default
// power-on hold length and the bus request qualifier.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    ST_POR       = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WAIT      = 3'd2,
    ST_STEP_HOLD = 3'd3,
    ST_ACK       = 3'd4
  } state_t;

  localparam int DEFAULT_RESET_CYCLES = 10000;

  // A bus cycle is live only when AS is accompanied by at least one data strobe.
  function automatic logic bus_req(input logic as_l, input logic uds_l, input logic lds_l);
    return as_l & (uds_l | lds_l);
  endfunction

endpackage

// File: rtl/bus_sequencer_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, with a one-clock pulse on
// each rising edge of the synchronised level.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  // Synchroniser chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Pulse is formed purely from flop outputs, so it is glitch-free.
  assign level = sync;
  assign rise  = sync & ~sync_d;

endmodule

// File: rtl/bus_sequencer.sv
// 68000 board bus controller: power-on RESET/HALT sequencing, DTACK generation
// with wait states, and single-step stalling of bus cycles.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int COUNT_W      = 14,
  parameter int WAIT_STATES  = 0,
  parameter int WAIT_W       = 4,
  parameter int CYC_W        = 16
) (
  input  logic             CPUCLK_IN,
  input  logic             RST_N_IN,
  input  logic             STEPEN_IN,
  input  logic             STEP_IN,
  input  logic             AS_IN,
  input  logic             UDS_IN,
  input  logic             LDS_IN,
  output logic             RESET,
  output logic             HALT,
  output logic             RUN,
  output logic             DTACK,
  output logic             STEP_WAIT,
  output logic [CYC_W-1:0] CYCLE_CNT
);

  localparam logic [COUNT_W-1:0] POR_LAST  = COUNT_W'(RESET_CYCLES - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(WAIT_STATES);

  state_t              state;
  logic [COUNT_W-1:0]  por_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                req;
  logic                stepen_sync;
  logic                stepen_rise_unused;
  logic                step_rise;

  assign req = bus_req(AS_IN, UDS_IN, LDS_IN);

  sync_edge u_sync_stepen (
    .clk   (CPUCLK_IN),
    .rst_n (RST_N_IN),
    .din   (STEPEN_IN),
    .level (stepen_sync),
    .rise  (stepen_rise_unused)
  );

  sync_edge u_sync_step (
    .clk   (CPUCLK_IN),
    .rst_n (RST_N_IN),
    .din   (STEP_IN),
    .level (),
    .rise  (step_rise)
  );

  // Bus sequencing FSM with all board-facing outputs registered.
  always_ff @(posedge CPUCLK_IN) begin
    if (!RST_N_IN) begin
      state     <= ST_POR;
      por_cnt   <= '0;
      wait_cnt  <= '0;
      RESET     <= 1'b0;
      HALT      <= 1'b0;
      RUN       <= 1'b0;
      DTACK     <= 1'b0;
      STEP_WAIT <= 1'b0;
      CYCLE_CNT <= '0;
    end else begin
      case (state)
        ST_POR: begin
          // Counter parks on its last value; it is only rearmed by reset.
          if (por_cnt == POR_LAST) begin
            RESET <= 1'b1;
            HALT  <= 1'b1;
            RUN   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            por_cnt <= por_cnt + COUNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (req) begin
            if (stepen_sync) begin
              STEP_WAIT <= 1'b1;
              state     <= ST_STEP_HOLD;
            end else if (WAIT_STATES == 0) begin
              DTACK <= 1'b1;
              state <= ST_ACK;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!AS_IN) begin
            state <= ST_IDLE;
          end else if (wait_cnt <= WAIT_W'(1)) begin
            DTACK <= 1'b1;
            state <= ST_ACK;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_STEP_HOLD: begin
          // Only a STEP edge releases the cycle; STEPEN changes are ignored here.
          if (!AS_IN) begin
            STEP_WAIT <= 1'b0;
            state     <= ST_IDLE;
          end else if (step_rise) begin
            STEP_WAIT <= 1'b0;
            DTACK     <= 1'b1;
            state     <= ST_ACK;
          end else begin
            state <= ST_STEP_HOLD;
          end
        end
        ST_ACK: begin
          if (!AS_IN) begin
            DTACK     <= 1'b0;
            CYCLE_CNT <= CYCLE_CNT + CYC_W'(1);
            state     <= ST_IDLE;
          end else begin
            DTACK <= 1'b1;
          end
        end
        default: begin
          DTACK     <= 1'b0;
          STEP_WAIT <= 1'b0;
          state     <= RUN ? ST_IDLE : ST_POR;
        end
      endcase
    end
  end

endmodule
